// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared types for the RAM-backed first-word-fall-through FIFO controller.
package mem_fifo_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } stage_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_fifo_ctrl_if.sv
// Push/pop handshake bundle between the FIFO controller and its producer/consumer.
interface mem_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  iPushValid;
  logic                  oPushReady;
  logic [DATA_WIDTH-1:0] iPushData;
  logic                  oPopValid;
  logic                  iPopReady;
  logic [DATA_WIDTH-1:0] oPopData;
  logic [ADDR_WIDTH+1:0] oCount;
  logic                  oEmpty;
  logic                  oDropped;

  modport master (
    output iPushValid, iPushData, iPopReady,
    input  oPushReady, oPopValid, oPopData, oCount, oEmpty, oDropped
  );

  modport slave (
    input  iPushValid, iPushData, iPopReady,
    output oPushReady, oPopValid, oPopData, oCount, oEmpty, oDropped
  );
endinterface

// File: rtl/mem_fifo_ctrl_ram.sv
// Dual-port RAM with one write port and one registered read port (read-before-write).
module mem_fifo_ctrl_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int MEM_SIZE   = 7
) (
  input  logic                  Clock,
  input  logic                  iWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [DATA_WIDTH-1:0] iDataIn,
  input  logic [ADDR_WIDTH-1:0] iReadAddress0,
  output logic [DATA_WIDTH-1:0] oDataOut0
);
  logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE];

  always_ff @(posedge Clock) begin
    if (iWriteEnable) begin
      mem[iWriteAddress] <= iDataIn;
    end
    oDataOut0 <= mem[iReadAddress0];
  end
endmodule

// File: rtl/mem_fifo_ctrl.sv
// FWFT FIFO controller around a registered-read dual-port RAM.
// A two-entry head/skid stage hides the RAM read latency from the consumer.
module mem_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  mem_fifo_ctrl_if.slave bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int OUT_W = ADDR_WIDTH + 2;
  localparam int OCC_W = clog2(3);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  stage_e                state;
  stage_e                state_n;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      ram_cnt;
  logic [CNT_W-1:0]      ram_cnt_n;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] head_n;
  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] skid_n;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      occ_n;
  logic [2:0]            pending;
  logic [OUT_W-1:0]      count_n;
  logic                  push;
  logic                  pop;
  logic                  rd_issue;
  logic                  push_rdy;
  logic                  pop_vld;
  logic [OUT_W-1:0]      count;
  logic                  empty;
  logic                  dropped;

  function automatic logic [OCC_W-1:0] occ_of(input stage_e s);
    case (s)
      S_ONE:   return OCC_W'(1);
      S_TWO:   return OCC_W'(2);
      default: return '0;
    endcase
  endfunction

  assign push    = bus.iPushValid && push_rdy;
  assign pop     = pop_vld && bus.iPopReady;
  assign occ     = occ_of(state);
  assign occ_n   = occ_of(state_n);
  assign pending = 3'(occ) + 3'(inflight);
  // A read is only issued when the stage is guaranteed room for it next cycle.
  assign rd_issue = (ram_cnt != '0) && (pending < (3'd2 + 3'(pop)));

  always_comb begin
    case ({push, rd_issue})
      2'b10:   ram_cnt_n = ram_cnt + CNT_W'(1);
      2'b01:   ram_cnt_n = ram_cnt - CNT_W'(1);
      default: ram_cnt_n = ram_cnt;
    endcase
  end

  assign count_n = OUT_W'(ram_cnt_n) + OUT_W'(rd_issue) + OUT_W'(occ_n);

  // p0: read issue into the RAM's registered read port
  mem_fifo_ctrl_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (DEPTH - 1)
  ) u_ram (
    .Clock         (Clock),
    .iWriteEnable  (push),
    .iWriteAddress (wr_ptr),
    .iDataIn       (bus.iPushData),
    .iReadAddress0 (rd_ptr),
    .oDataOut0     (ram_dout)
  );

  // p1: RAM output captured into head/skid when a read is in flight
  always_comb begin
    state_n = state;
    head_n  = head;
    skid_n  = skid;
    case (state)
      S_EMPTY: begin
        if (inflight) begin
          state_n = S_ONE;
          head_n  = ram_dout;
        end
      end
      S_ONE: begin
        case ({inflight, pop})
          2'b10: begin
            state_n = S_TWO;
            skid_n  = ram_dout;
          end
          2'b01:   state_n = S_EMPTY;
          2'b11:   head_n  = ram_dout;
          default: state_n = S_ONE;
        endcase
      end
      S_TWO: begin
        if (pop) begin
          head_n  = skid;
          state_n = S_ONE;
          if (inflight) begin
            skid_n  = ram_dout;
            state_n = S_TWO;
          end
        end
      end
      default: state_n = S_EMPTY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      head     <= '0;
      push_rdy <= 1'b0;
      pop_vld  <= 1'b0;
      count    <= '0;
      empty    <= 1'b1;
      dropped  <= 1'b0;
    end else begin
      state    <= state_n;
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      ram_cnt  <= ram_cnt_n;
      inflight <= rd_issue;
      head     <= head_n;
      push_rdy <= (ram_cnt_n != FULL);
      pop_vld  <= (state_n != S_EMPTY);
      count    <= count_n;
      empty    <= (count_n == '0);
      dropped  <= bus.iPushValid && !push_rdy;
    end
  end

  always_ff @(posedge Clock) begin
    skid <= skid_n;
  end

  assign bus.oPushReady = push_rdy;
  assign bus.oPopValid  = pop_vld;
  assign bus.oPopData   = head;
  assign bus.oCount     = count;
  assign bus.oEmpty     = empty;
  assign bus.oDropped   = dropped;
endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Directed bench for mem_fifo_ctrl: reset, latency, fill/drop, streaming, stalls, reset flush, full push+pop.
module tb_mem_fifo_ctrl;
  logic Clock = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  always #5 Clock = ~Clock;

  mem_fifo_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  mem_fifo_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iPushValid = 1'b0;
    bus.iPushData  = 16'h0000;
    bus.iPopReady  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.oPushReady !== 1'b0) begin errors++; $display("FAIL rst_push_ready: got %b want 0", bus.oPushReady); end
    checks++; if (bus.oPopValid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid: got %b want 0", bus.oPopValid); end
    checks++; if (bus.oPopData !== 16'h0000) begin errors++; $display("FAIL rst_pop_data: got %h want 0000", bus.oPopData); end
    checks++; if (bus.oCount !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.oCount); end
    checks++; if (bus.oEmpty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", bus.oEmpty); end
    checks++; if (bus.oDropped !== 1'b0) begin errors++; $display("FAIL rst_dropped: got %b want 0", bus.oDropped); end
    Reset = 1'b0;
    tick();
    checks++; if (bus.oPushReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.oPushReady); end
    checks++; if (bus.oCount !== 5'd0) begin errors++; $display("FAIL rst_release_count: got %0d want 0", bus.oCount); end
  endtask

  task automatic test_single();
    bus.iPushValid = 1'b1;
    bus.iPushData  = 16'hA5A5;
    bus.iPopReady  = 1'b1;
    tick();
    bus.iPushValid = 1'b0;
    checks++; if (bus.oCount !== 5'd1) begin errors++; $display("FAIL t1_count_n1: got %0d want 1", bus.oCount); end
    checks++; if (bus.oEmpty !== 1'b0) begin errors++; $display("FAIL t1_empty_n1: got %b want 0", bus.oEmpty); end
    checks++; if (bus.oPopValid !== 1'b0) begin errors++; $display("FAIL t1_valid_n1: got %b want 0", bus.oPopValid); end
    tick();
    checks++; if (bus.oPopValid !== 1'b0) begin errors++; $display("FAIL t1_valid_n2: got %b want 0", bus.oPopValid); end
    tick();
    checks++; if (bus.oPopValid !== 1'b1) begin errors++; $display("FAIL t1_valid_n3: got %b want 1", bus.oPopValid); end
    checks++; if (bus.oPopData !== 16'hA5A5) begin errors++; $display("FAIL t1_data_n3: got %h want a5a5", bus.oPopData); end
    checks++; if (bus.oCount !== 5'd1) begin errors++; $display("FAIL t1_count_n3: got %0d want 1", bus.oCount); end
    tick();
    checks++; if (bus.oPopValid !== 1'b0) begin errors++; $display("FAIL t1_valid_n4: got %b want 0", bus.oPopValid); end
    checks++; if (bus.oCount !== 5'd0) begin errors++; $display("FAIL t1_count_n4: got %0d want 0", bus.oCount); end
    checks++; if (bus.oEmpty !== 1'b1) begin errors++; $display("FAIL t1_empty_n4: got %b want 1", bus.oEmpty); end
    idle_inputs();
  endtask

  task automatic test_fill_drop();
    int rx;
    bus.iPopReady = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      bus.iPushValid = 1'b1;
      bus.iPushData  = 16'(k);
      if (k == 10) begin
        checks++; if (bus.oPushReady !== 1'b0) begin errors++; $display("FAIL t2_ready_at_full: got %b want 0", bus.oPushReady); end
      end
      tick();
    end
    bus.iPushValid = 1'b0;
    checks++; if (bus.oDropped !== 1'b1) begin errors++; $display("FAIL t2_dropped: got %b want 1", bus.oDropped); end
    checks++; if (bus.oCount !== 5'd10) begin errors++; $display("FAIL t2_count: got %0d want 10", bus.oCount); end
    checks++; if (bus.oPushReady !== 1'b0) begin errors++; $display("FAIL t2_ready: got %b want 0", bus.oPushReady); end
    tick();
    checks++; if (bus.oDropped !== 1'b0) begin errors++; $display("FAIL t2_dropped_pulse: got %b want 0", bus.oDropped); end
    bus.iPopReady = 1'b1;
    rx = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.oPopValid === 1'b1) begin
        checks++; if (bus.oPopData !== 16'(rx)) begin errors++; $display("FAIL t2_drain_data: got %h want %h", bus.oPopData, 16'(rx)); end
        rx++;
      end
      tick();
    end
    checks++; if (rx != 10) begin errors++; $display("FAIL t2_drain_total: got %0d want 10", rx); end
    checks++; if (bus.oCount !== 5'd0) begin errors++; $display("FAIL t2_drain_count: got %0d want 0", bus.oCount); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int rx;
    rx = 0;
    bus.iPopReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.iPushValid = 1'b1;
      bus.iPushData  = 16'(32'h0100 + i);
      if (bus.oPopValid === 1'b1) begin
        checks++; if (bus.oPopData !== 16'(32'h0100 + rx)) begin errors++; $display("FAIL t3_data: got %h want %h", bus.oPopData, 16'(32'h0100 + rx)); end
        rx++;
      end
      if (i >= 3) begin
        checks++; if (bus.oPopValid !== 1'b1) begin errors++; $display("FAIL t3_rate: cycle %0d valid got %b want 1", i, bus.oPopValid); end
      end
      checks++; if (bus.oDropped !== 1'b0) begin errors++; $display("FAIL t3_dropped: got %b want 0", bus.oDropped); end
      tick();
    end
    bus.iPushValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.oPopValid === 1'b1) begin
        checks++; if (bus.oPopData !== 16'(32'h0100 + rx)) begin errors++; $display("FAIL t3_tail: got %h want %h", bus.oPopData, 16'(32'h0100 + rx)); end
        rx++;
      end
      tick();
    end
    checks++; if (rx != 100) begin errors++; $display("FAIL t3_total: got %0d want 100", rx); end
    idle_inputs();
  endtask

  task automatic test_random_stall();
    logic [15:0] q[$];
    logic [15:0] held;
    logic [15:0] nxt;
    logic        stalled;
    int          pushed;
    held    = 16'h0000;
    nxt     = 16'h2000;
    stalled = 1'b0;
    pushed  = 0;
    for (int c = 0; c < 400; c++) begin
      bus.iPushValid = ($urandom_range(0, 9) < 7) && (bus.oPushReady === 1'b1);
      bus.iPushData  = nxt;
      bus.iPopReady  = ($urandom_range(0, 9) < 4);
      if (stalled) begin
        checks++; if (bus.oPopValid !== 1'b1 || bus.oPopData !== held) begin errors++; $display("FAIL t4_stable: got v=%b d=%h want v=1 d=%h", bus.oPopValid, bus.oPopData, held); end
      end
      if (bus.oPopValid === 1'b1 && bus.iPopReady) begin
        checks++; if (q.size() == 0 || bus.oPopData !== q[0]) begin errors++; $display("FAIL t4_order: got %h want %h", bus.oPopData, (q.size() == 0) ? 16'hxxxx : q[0]); end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (bus.iPushValid) begin
        q.push_back(nxt);
        nxt++;
        pushed++;
      end
      checks++; if (bus.oDropped !== 1'b0) begin errors++; $display("FAIL t4_dropped: got %b want 0", bus.oDropped); end
      stalled = (bus.oPopValid === 1'b1) && !bus.iPopReady;
      held    = bus.oPopData;
      tick();
    end
    bus.iPushValid = 1'b0;
    bus.iPopReady  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.oPopValid === 1'b1) begin
        checks++; if (q.size() == 0 || bus.oPopData !== q[0]) begin errors++; $display("FAIL t4_drain: got %h want %h", bus.oPopData, (q.size() == 0) ? 16'hxxxx : q[0]); end
        if (q.size() != 0) void'(q.pop_front());
      end
      tick();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL t4_leftover: got %0d words want 0", q.size()); end
    checks++; if (pushed < 40) begin errors++; $display("FAIL t4_wraps: got %0d pushes want >=40", pushed); end
    checks++; if (bus.oEmpty !== 1'b1) begin errors++; $display("FAIL t4_empty: got %b want 1", bus.oEmpty); end
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    bus.iPopReady = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.iPushValid = 1'b1;
      bus.iPushData  = 16'(32'h50 + k);
      tick();
    end
    bus.iPushValid = 1'b0;
    tick();
    checks++; if (bus.oCount !== 5'd6) begin errors++; $display("FAIL t5_count_six: got %0d want 6", bus.oCount); end
    bus.iPushValid = 1'b1;
    bus.iPushData  = 16'h0056;
    bus.iPopReady  = 1'b1;
    checks++; if (bus.oPopData !== 16'h0050) begin errors++; $display("FAIL t5_head: got %h want 0050", bus.oPopData); end
    tick();
    idle_inputs();
    checks++; if (bus.oCount !== 5'd6) begin errors++; $display("FAIL t5_count_inflight: got %0d want 6", bus.oCount); end
    Reset = 1'b1;
    tick();
    checks++; if (bus.oCount !== 5'd0) begin errors++; $display("FAIL t5_rst_count: got %0d want 0", bus.oCount); end
    checks++; if (bus.oPopValid !== 1'b0) begin errors++; $display("FAIL t5_rst_valid: got %b want 0", bus.oPopValid); end
    checks++; if (bus.oEmpty !== 1'b1) begin errors++; $display("FAIL t5_rst_empty: got %b want 1", bus.oEmpty); end
    Reset = 1'b0;
    tick();
    checks++; if (bus.oPushReady !== 1'b1) begin errors++; $display("FAIL t5_ready: got %b want 1", bus.oPushReady); end
    bus.iPushValid = 1'b1;
    bus.iPushData  = 16'h1234;
    bus.iPopReady  = 1'b1;
    tick();
    bus.iPushValid = 1'b0;
    for (int w = 0; w < 8 && bus.oPopValid !== 1'b1; w++) tick();
    checks++; if (bus.oPopValid !== 1'b1 || bus.oPopData !== 16'h1234) begin errors++; $display("FAIL t5_first_word: got v=%b d=%h want v=1 d=1234", bus.oPopValid, bus.oPopData); end
    tick();
    tick();
    checks++; if (bus.oPopValid !== 1'b0 || bus.oCount !== 5'd0) begin errors++; $display("FAIL t5_no_stale: got v=%b cnt=%0d want v=0 cnt=0", bus.oPopValid, bus.oCount); end
    idle_inputs();
  endtask

  task automatic test_full_push_pop();
    int rx;
    bus.iPopReady = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.iPushValid = 1'b1;
      bus.iPushData  = 16'(32'h60 + k);
      tick();
    end
    bus.iPushValid = 1'b0;
    tick();
    tick();
    checks++; if (bus.oCount !== 5'd10) begin errors++; $display("FAIL t6_full_count: got %0d want 10", bus.oCount); end
    checks++; if (bus.oPushReady !== 1'b0) begin errors++; $display("FAIL t6_full_ready: got %b want 0", bus.oPushReady); end
    bus.iPushValid = 1'b1;
    bus.iPushData  = 16'hBEEF;
    bus.iPopReady  = 1'b1;
    checks++; if (bus.oPopData !== 16'h0060) begin errors++; $display("FAIL t6_head: got %h want 0060", bus.oPopData); end
    tick();
    idle_inputs();
    checks++; if (bus.oPushReady !== 1'b1) begin errors++; $display("FAIL t6_ready_after: got %b want 1", bus.oPushReady); end
    checks++; if (bus.oDropped !== 1'b1) begin errors++; $display("FAIL t6_dropped: got %b want 1", bus.oDropped); end
    checks++; if (bus.oCount !== 5'd9) begin errors++; $display("FAIL t6_count_after: got %0d want 9", bus.oCount); end
    bus.iPopReady = 1'b1;
    rx = 1;
    for (int c = 0; c < 30; c++) begin
      if (bus.oPopValid === 1'b1) begin
        checks++; if (bus.oPopData !== 16'(32'h60 + rx)) begin errors++; $display("FAIL t6_drain: got %h want %h", bus.oPopData, 16'(32'h60 + rx)); end
        rx++;
      end
      tick();
    end
    checks++; if (rx != 10) begin errors++; $display("FAIL t6_drain_total: got %0d want 10", rx); end
    checks++; if (bus.oEmpty !== 1'b1) begin errors++; $display("FAIL t6_empty: got %b want 1", bus.oEmpty); end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_drop();
    test_back_to_back();
    test_random_stall();
    test_reset_inflight();
    test_full_push_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
